// File: rtl/riscuin_mcu_pkg.sv
// Shared types and sizing for the MCU control link responder.
// Imported by the link interface and the link slave.
package riscuin_mcu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_DELIVER,
      ST_ACK
   } link_state_t;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   function automatic int frame_bits(
      input int addr_w,
      input int data_w
   );
      return addr_w + data_w;
   endfunction

endpackage

// File: rtl/mcu_link_slave_if.sv
// Core-side valid/ready write channel of the MCU link.
// The master drives the frame; the slave accepts it.
interface mcu_link_slave_if
   import riscuin_mcu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/mcu_link_slave_sync.sv
// Generic multi-stage synchronizer for one asynchronous input.
// RST_VAL is the idle level of the input it guards.
module sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= {STAGES{RST_VAL}};
      else        sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/mcu_link_slave.sv
// SPI mode-0 write-frame receiver with valid/ready delivery
// and a four-phase REQ/ACK close-out toward the MCU.
module mcu_link_slave
   import riscuin_mcu_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic SYS_CLK,
   input  logic SYS_RSTn,
   input  logic MCU_SPI_SCLK,
   input  logic MCU_SPI_CS,
   input  logic MCU_SPI_MOSI,
   input  logic MCU_REQ,
   output logic MCU_ACK,
   output logic frame_err,
   mcu_link_slave_if.master wr
);

   localparam int FB = frame_bits(ADDR_W, DATA_W);
   localparam int CW = $clog2(FB + 2);

   logic cs_s, sclk_s, mosi_s, req_s;
   logic cs_d, sclk_d;
   logic cs_fall, cs_rise, sclk_rise;

   link_state_t state, state_n;

   logic [FB-1:0]     shreg;
   logic [CW-1:0]     cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic valid_q, valid_n;
   logic ack_q, ack_n;
   logic err_q, err_n;
   logic load;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(SYS_CLK), .rst_n(SYS_RSTn),
      .d(MCU_SPI_CS), .q(cs_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(SYS_CLK), .rst_n(SYS_RSTn),
      .d(MCU_SPI_SCLK), .q(sclk_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(SYS_CLK), .rst_n(SYS_RSTn),
      .d(MCU_SPI_MOSI), .q(mosi_s)
   );

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_req (
      .clk(SYS_CLK), .rst_n(SYS_RSTn),
      .d(MCU_REQ), .q(req_s)
   );

   always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) begin
         cs_d   <= 1'b1;
         sclk_d <= 1'b0;
      end else begin
         cs_d   <= cs_s;
         sclk_d <= sclk_s;
      end
   end

   assign cs_fall   = cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_rise = ~sclk_d & sclk_s;

   // Only a frame accepted from IDLE is shifted; busy frames are dropped.
   always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (state == ST_IDLE && cs_fall) begin
         cnt <= '0;
      end else if (state == ST_SHIFT && !cs_s && sclk_rise) begin
         shreg <= {shreg[FB-2:0], mosi_s};
         if (cnt != CW'(FB + 1)) cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) state <= ST_IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      valid_n = valid_q;
      ack_n   = ack_q;
      err_n   = 1'b0;
      load    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cs_fall) state_n = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               if (cnt == CW'(FB)) begin
                  state_n = ST_HOLD;
                  load    = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  err_n   = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (req_s) begin
               state_n = ST_DELIVER;
               valid_n = 1'b1;
            end
         end
         ST_DELIVER: begin
            if (valid_q && wr.wr_ready) begin
               state_n = ST_ACK;
               valid_n = 1'b0;
               ack_n   = 1'b1;
            end
         end
         ST_ACK: begin
            if (!req_s) begin
               state_n = ST_IDLE;
               ack_n   = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (cs_fall &&
          (state == ST_HOLD ||
           state == ST_DELIVER ||
           state == ST_ACK))
         err_n = 1'b1;
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
      if (!SYS_RSTn) begin
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_n;
         ack_q   <= ack_n;
         err_q   <= err_n;
         if (load) begin
            addr_q <= shreg[FB-1 -: ADDR_W];
            data_q <= shreg[DATA_W-1:0];
         end
      end
   end

   assign wr.wr_valid = valid_q;
   assign wr.wr_addr  = addr_q;
   assign wr.wr_data  = data_q;
   assign MCU_ACK     = ack_q;
   assign frame_err   = err_q;

endmodule

// File: tb/tb_mcu_link_slave.sv
// Vector table plus scoreboard bench for mcu_link_slave.
module tb_mcu_link_slave;

   logic clk = 1'b0;
   logic rst_n;
   logic sclk, cs, mosi, req;
   logic ack, ferr;

   int errors = 0;
   int checks = 0;
   int err_cnt = 0;
   int deliv_cnt = 0;
   int n_exp = 0;

   logic [15:0] exp_q[$];

   typedef struct {
      logic [31:0] bits;
      int          nbits;
      int          ready_dly;
      int          exp_err;
      bit          exp_ack;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   mcu_link_slave_if #(.ADDR_W(8), .DATA_W(8)) wr_if ();

   mcu_link_slave #(
      .ADDR_W(8), .DATA_W(8), .SYNC_STAGES(2)
   ) dut (
      .SYS_CLK(clk),
      .SYS_RSTn(rst_n),
      .MCU_SPI_SCLK(sclk),
      .MCU_SPI_CS(cs),
      .MCU_SPI_MOSI(mosi),
      .MCU_REQ(req),
      .MCU_ACK(ack),
      .frame_err(ferr),
      .wr(wr_if)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [31:0] v,
                           input int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         cyc(4);
         sclk = 1'b1;
         cyc(4);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_frame(input logic [31:0] v,
                            input int n);
      cs = 1'b0;
      cyc(4);
      spi_bits(v, n);
      cyc(4);
      cs = 1'b1;
   endtask

   task automatic push(input logic [15:0] f);
      exp_q.push_back(f);
      n_exp++;
   endtask

   logic       err_prev = 1'b0;
   logic       val_prev = 1'b0;
   logic [7:0] addr_prev, data_prev;

   always @(negedge clk) begin
      logic [15:0] e;
      if (ferr) err_cnt++;
      if (err_prev) chk("err_width", ferr, 1'b0);
      if (val_prev && wr_if.wr_valid) begin
         chk("addr_stable", wr_if.wr_addr, addr_prev);
         chk("data_stable", wr_if.wr_data, data_prev);
      end
      if (wr_if.wr_valid && wr_if.wr_ready) begin
         deliv_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_if.wr_addr, e[15:8]);
            chk("wr_data", wr_if.wr_data, e[7:0]);
         end
      end
      err_prev  = ferr;
      val_prev  = wr_if.wr_valid;
      addr_prev = wr_if.wr_addr;
      data_prev = wr_if.wr_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int e0;
      vecs[0] = '{32'hA53C,  16, 0,  0, 1'b1};
      vecs[1] = '{32'h1234,  16, 20, 0, 1'b1};
      vecs[2] = '{32'h1234,  15, 0,  1, 1'b0};
      vecs[3] = '{32'h12345, 17, 0,  1, 1'b0};
      vecs[4] = '{32'h0000,  16, 0,  0, 1'b1};
      vecs[5] = '{32'hFFFF,  16, 0,  0, 1'b1};
      vecs[6] = '{32'h8001,  16, 3,  0, 1'b1};

      rst_n = 1'b0;
      cs = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      req = 1'b0;
      wr_if.wr_ready = 1'b0;
      cyc(3);
      chk("rst_ack", ack, 1'b0);
      chk("rst_valid", wr_if.wr_valid, 1'b0);
      chk("rst_addr", wr_if.wr_addr, 8'h00);
      chk("rst_data", wr_if.wr_data, 8'h00);
      chk("rst_err", ferr, 1'b0);
      rst_n = 1'b1;
      cyc(4);

      for (int v = 0; v < 7; v++) begin
         e0 = err_cnt;
         wr_if.wr_ready = (vecs[v].ready_dly == 0);
         if (vecs[v].exp_ack) push(vecs[v].bits[15:0]);
         spi_frame(vecs[v].bits, vecs[v].nbits);
         cyc(6);
         req = 1'b1;
         cyc(2);
         chk("valid_early", wr_if.wr_valid, 1'b0);
         cyc(1);
         chk("valid_rise", wr_if.wr_valid,
             vecs[v].exp_ack);
         if (vecs[v].exp_ack) begin
            for (int d = 0; d < vecs[v].ready_dly; d++) begin
               cyc(1);
               chk("bp_valid", wr_if.wr_valid, 1'b1);
               chk("bp_ack", ack, 1'b0);
            end
            wr_if.wr_ready = 1'b1;
            cyc(1);
            chk("ack_rise", ack, 1'b1);
            chk("valid_fall", wr_if.wr_valid, 1'b0);
            req = 1'b0;
            cyc(2);
            chk("ack_hold", ack, 1'b1);
            cyc(1);
            chk("ack_fall", ack, 1'b0);
         end else begin
            cyc(10);
            chk("no_ack", ack, 1'b0);
            req = 1'b0;
         end
         cyc(4);
         chk("err_pulses", err_cnt - e0, vecs[v].exp_err);
      end

      wr_if.wr_ready = 1'b0;
      push(16'h0102);
      spi_frame(32'h0102, 16);
      cyc(6);
      req = 1'b1;
      cyc(3);
      chk("busy_valid", wr_if.wr_valid, 1'b1);
      e0 = err_cnt;
      spi_frame(32'hFFFF, 16);
      cyc(4);
      chk("busy_err", err_cnt - e0, 1);
      chk("busy_still_valid", wr_if.wr_valid, 1'b1);
      chk("busy_addr", wr_if.wr_addr, 8'h01);
      chk("busy_data", wr_if.wr_data, 8'h02);
      wr_if.wr_ready = 1'b1;
      cyc(1);
      chk("busy_ack", ack, 1'b1);
      req = 1'b0;
      cyc(3);
      chk("busy_ack_fall", ack, 1'b0);
      cyc(4);

      cs = 1'b0;
      cyc(4);
      spi_bits(32'h55, 8);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_addr", wr_if.wr_addr, 8'h00);
      chk("mid_rst_data", wr_if.wr_data, 8'h00);
      chk("mid_rst_valid", wr_if.wr_valid, 1'b0);
      chk("mid_rst_ack", ack, 1'b0);
      chk("mid_rst_err", ferr, 1'b0);
      cs = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(4);
      push(16'h55AA);
      spi_frame(32'h55AA, 16);
      cyc(6);
      req = 1'b1;
      cyc(3);
      chk("post_rst_valid", wr_if.wr_valid, 1'b1);
      cyc(1);
      chk("post_rst_ack", ack, 1'b1);
      req = 1'b0;
      cyc(6);
      chk("post_rst_ack_fall", ack, 1'b0);

      chk("queue_empty", exp_q.size(), 0);
      chk("deliveries", deliv_cnt, n_exp);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/mcu_link_slave.md
# mcu_link_slave

FPGA-side responder for the MCU control link on the Tang Nano board. It receives fixed-length write frames from the MCU over a SPI mode-0 link (SCLK/CS/MOSI) and presents each frame to the core as a valid/ready write. It then closes the transaction with a four-phase `MCU_REQ`/`MCU_ACK` handshake. It sits between the board MCU pins and the CPU-side register/bus logic in the top level.

## Interface
Parameters:
- `ADDR_W`, 8, address field width
- `DATA_W`, 8, data field width
- `SYNC_STAGES`, 2, flip-flop stages per asynchronous input (≥2)

Ports (one clock, `SYS_CLK`; reset `SYS_RSTn` is asynchronous, active-low):
- `SYS_CLK`  in  1  system clock
- `SYS_RSTn`  in  1  asynchronous active-low reset
- `MCU_SPI_SCLK`  in  1  SPI clock from MCU, async
- `MCU_SPI_CS`  in  1  SPI chip select, active-low, async
- `MCU_SPI_MOSI`  in  1  SPI data, MSB first, async
- `MCU_REQ`  in  1  MCU transaction request, async
- `MCU_ACK`  out  1  transaction acknowledge to MCU
- `wr_valid`  out  1  frame available to core
- `wr_ready`  in  1  core accepts frame
- `wr_addr`  out  `ADDR_W`  frame address field
- `wr_data`  out  `DATA_W`  frame data field
- `frame_err`  out  1  one-cycle pulse on a discarded frame

## Operation
- `FRAME_BITS = ADDR_W + DATA_W`. Frame layout, MSB first: `{addr, data}`.
- All four MCU inputs pass through `SYNC_STAGES` synchronizers. Edges are detected on the synchronized signals only.
- `MCU_SPI_SCLK` must not exceed `SYS_CLK`/4 (each high and low phase ≥ 2 `SYS_CLK` cycles).
- Shifting occurs on the synchronized SCLK rising edge while synchronized CS is low. A saturating bit counter counts received bits.
- FSM states: IDLE, SHIFT, HOLD, DELIVER, ACK.
  - IDLE → SHIFT on CS falling edge. The counter is cleared at this point.
  - SHIFT → HOLD on CS rising edge when count == `FRAME_BITS`. The shift register is copied to the `wr_addr`/`wr_data` holding register.
  - SHIFT → IDLE on CS rising edge with count ≠ `FRAME_BITS` (short or long frame). `frame_err` pulses; the holding register is unchanged.
  - HOLD → DELIVER when synchronized `MCU_REQ` is high. `wr_valid` is asserted.
  - DELIVER → ACK on the cycle where `wr_valid & wr_ready` are both high. `wr_valid` is deasserted and `MCU_ACK` is asserted.
  - ACK → IDLE when synchronized `MCU_REQ` goes low. `MCU_ACK` is deasserted.
- `MCU_REQ` is ignored in IDLE and SHIFT.
- A CS falling edge in HOLD, DELIVER or ACK is not accepted. `frame_err` pulses once, and SCLK edges are ignored until CS returns high. The held frame and the FSM state are unaffected.
- `wr_addr`/`wr_data` stay stable while `wr_valid` is high.
- Reset mid-transaction: the FSM returns to IDLE and the frame is lost. The MCU must restart at CS.

## Timing
- Reset values: `MCU_ACK`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_err`=0. All synchronizers reset to their idle level: CS=1, SCLK=0, REQ=0.
- CS rising at the pin → HOLD: `SYNC_STAGES`+1 cycles.
- `MCU_REQ` rising at the pin → `wr_valid` high: `SYNC_STAGES`+1 cycles (if the FSM is already in HOLD).
- `wr_valid & wr_ready` → `MCU_ACK` high: the next cycle.
- `MCU_REQ` falling at the pin → `MCU_ACK` low: `SYNC_STAGES`+1 cycles.
- `frame_err` is exactly one cycle wide, registered, and follows the qualifying edge by 1 cycle.
- All outputs are driven from registers; there are no combinational paths from input to output.

## Structure
- Shared package `riscuin_mcu_pkg` holds:
  - the FSM state enum
  - default `ADDR_W`/`DATA_W`
  - the `FRAME_BITS` derivation
- Sub-module `sync_ff` is a generic `SYNC_STAGES`-deep synchronizer with a reset-value parameter, instantiated once per MCU input.
- Edge detection, the shifter, and the FSM live in `mcu_link_slave`.

## Test plan
- Nominal write: send frame `0xA5_3C` at SCLK = `SYS_CLK`/8, then raise REQ with `wr_ready`=1 → `wr_valid` for 1 cycle with addr `0xA5`, data `0x3C`; `MCU_ACK` rises; drop REQ → `MCU_ACK` falls. No `frame_err`.
- Back-pressure: hold `wr_ready`=0 for 20 cycles → `wr_valid` stays high with stable `0x12_34`; `MCU_ACK` stays low; ACK rises 1 cycle after `wr_ready`=1.
- Bad length: send a 15-bit frame, then a 17-bit frame → `frame_err` pulses twice, no `wr_valid`, and a following REQ produces no `MCU_ACK`.
- Busy overlap: start a second frame `0xFF_FF` while in DELIVER → one `frame_err` pulse; the first frame `0x01_02` is delivered intact.
- Reset mid-frame: deassert `SYS_RSTn` after 8 bits → all outputs 0 at once; a full frame `0x55_AA` after release is received correctly.
- Back-to-back transactions with `0x00_00` and `0xFF_FF` → both delivered in order; no stale data.
